hazard_md_ctrl: RTL and testbench
=================================

Name: hazard_md_ctrl

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W). It generalises the Tuse/Tnew hazard unit to parametrised register-address and timing widths. It adds a multi-cycle multiply/divide (HI/LO) busy tracker and a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives the PC/FD enables, the DE clear and all forwarding-mux selects.

Parameters:
AW, 5, register address width (rs/rt/A3 fields)
TW, 3, width of Tuse/Tnew fields
MULT_CYCLES, 5, busy cycles after a mult/multu enters E
DIV_CYCLES, 10, busy cycles after a div/divu enters E
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
rs_D, rt_D  in  AW each  source register fields of the instruction in D
tuse_rs_D, tuse_rt_D  in  TW each  cycles until D needs rs/rt (0 = needed in D)
md_use_D  in  1  instruction in D reads or writes HI/LO, or is mult/div
rs_E, rt_E  in  AW each  source fields in E
a3_E, a3_M, a3_W  in  AW each  destination register per stage (0 = no write)
tnew_E, tnew_M  in  TW each  cycles until the stage's result is produced (W is always 0)
md_start_E  in  1  mult/div is in E this cycle
md_div_E  in  1  1 = divide, 0 = multiply (valid with md_start_E)
rt_M  in  AW  store-data source field in M
fwd_d_rs, fwd_d_rt  out  2 each  D-stage mux select: 0 regfile, 1 E, 2 M, 3 W
fwd_e_rs, fwd_e_rt  out  2 each  E-stage select: 0 pipeline, 2 M, 3 W (1 never driven)
fwd_m_rt  out  2  M-stage select: 0 pipeline, 3 W
stall  out  1  hazard stall this cycle
pc_en, fd_en  out  1 each  equal to ~stall
de_clr  out  1  equal to stall (inserts a bubble in E)
md_busy  out  1  HI/LO unit is busy
stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Forward match rule: a stage X matches source s when a3_X != 0 and a3_X == s.
- Forward priority: the nearest stage wins (E > M > W for D; M > W for E; W only for M).
- The selected code is that stage's code if the winning stage's tnew == 0. Otherwise the code is 0; no fall-through to a farther stage.
- All forwarding outputs are combinational.
- Data stall: set when a match on rs_D (or rt_D) in E has tnew_E > tuse, or a match in M has tnew_M > tuse. W never causes a stall.
- md busy counter, width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)):
  - Reset value: 0.
  - On a rising edge with md_start_E = 1, it loads (md_div_E ? DIV_CYCLES : MULT_CYCLES) - 1.
  - Otherwise it decrements while nonzero and holds at 0.
- md_busy = md_start_E | (counter != 0). A start is therefore busy in its own E cycle plus N-1 further cycles, N cycles in total.
- md stall = md_use_D & md_busy.
- stall = data stall | md stall.
- A new md_start_E while the counter is nonzero is impossible by construction, because D was stalled. If it occurs anyway, the counter reloads; this must not be flagged as an error.
- stall_cnt increments by 1 on each rising edge where stall = 1, and saturates at all-ones.
- Reset (asynchronous, reset_n = 0) clears the md counter and stall_cnt immediately.
- Combinational outputs follow their inputs during reset. md_busy during reset reflects md_start_E only.
- Reset asserted mid-operation aborts the busy count; after release, md_busy = 0 unless md_start_E is asserted.

Test Plan:
- Forward priority: a3_E = 8 with tnew_E = 0, a3_M = 8, rs_D = 8, tuse = 1 -> fwd_d_rs = 1, stall = 0. Change tnew_E to 1 -> fwd_d_rs = 0, stall = 0 (tnew_E 1 ≤ tuse 1).
- Load-use: a3_E = 3, tnew_E = 2, rt_D = 3, tuse_rt_D = 1 -> stall = 1, pc_en = 0, de_clr = 1, stall_cnt +1 per edge. Next cycle, a3_M = 3, tnew_M = 1 -> stall = 0.
- $0 filter: a3_E = 0, rs_D = 0, tnew_E = 2, tuse = 0 -> stall = 0, fwd_d_rs = 0.
- Divide busy (DIV_CYCLES = 10): md_start_E = 1, md_div_E = 1 for one cycle, md_use_D = 1 held -> stall = 1 for exactly 10 cycles, then 0. Mult gives 5 cycles.
- Async reset mid-divide: reset_n pulsed low 4 cycles after the start -> md_busy = 0 and stall_cnt = 0 immediately, without waiting for a clock edge.
- Saturation (CNT_W = 4): hold a stall for 20 cycles -> stall_cnt = 15 and stays at 15.

Source files
------------

// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: Tuse/Tnew stall and forwarding control with HI/LO busy tracking and stall counter
module hazard_md_ctrl #(
    parameter int AW          = 5,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    rs_D,
    input  logic [AW-1:0]    rt_D,
    input  logic [TW-1:0]    tuse_rs_D,
    input  logic [TW-1:0]    tuse_rt_D,
    input  logic             md_use_D,
    input  logic [AW-1:0]    rs_E,
    input  logic [AW-1:0]    rt_E,
    input  logic [AW-1:0]    a3_E,
    input  logic [AW-1:0]    a3_M,
    input  logic [AW-1:0]    a3_W,
    input  logic [TW-1:0]    tnew_E,
    input  logic [TW-1:0]    tnew_M,
    input  logic             md_start_E,
    input  logic             md_div_E,
    input  logic [AW-1:0]    rt_M,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [1:0]       fwd_m_rt,
    output logic             stall,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int BW   = $clog2(MAXC + 1);

    logic [BW-1:0] md_cnt;
    logic          data_stall;

    // register $0 is never a real producer
    function automatic logic hit(input logic [AW-1:0] a3, input logic [AW-1:0] s);
        return a3 != '0 && a3 == s;
    endfunction

    // nearest matching stage decides; an unready winner yields 0 rather than an older value
    function automatic logic [1:0] sel_d(input logic [AW-1:0] s);
        return hit(a3_E, s) ? (tnew_E == '0 ? 2'd1 : 2'd0) :
               hit(a3_M, s) ? (tnew_M == '0 ? 2'd2 : 2'd0) :
               hit(a3_W, s) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [AW-1:0] s);
        return hit(a3_M, s) ? (tnew_M == '0 ? 2'd2 : 2'd0) :
               hit(a3_W, s) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic need_stall(input logic [AW-1:0] s, input logic [TW-1:0] tuse);
        return (hit(a3_E, s) && tnew_E > tuse) || (hit(a3_M, s) && tnew_M > tuse);
    endfunction

    assign fwd_d_rs   = sel_d(rs_D);
    assign fwd_d_rt   = sel_d(rt_D);
    assign fwd_e_rs   = sel_e(rs_E);
    assign fwd_e_rt   = sel_e(rt_E);
    assign fwd_m_rt   = hit(a3_W, rt_M) ? 2'd3 : 2'd0;
    assign data_stall = need_stall(rs_D, tuse_rs_D) || need_stall(rt_D, tuse_rt_D);
    assign md_busy    = md_start_E || md_cnt != '0;
    assign stall      = data_stall || (md_use_D && md_busy);
    assign pc_en      = ~stall;
    assign fd_en      = ~stall;
    assign de_clr     = stall;

    // busy countdown: the start cycle itself is covered by md_start_E, so load N-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            md_cnt <= '0;
        else if (md_start_E)
            md_cnt <= md_div_E ? BW'(DIV_CYCLES - 1) : BW'(MULT_CYCLES - 1);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_md_ctrl.sv
// tb_hazard_md_ctrl: scoreboard bench for the hazard/forwarding controller
module tb_hazard_md_ctrl;
    logic       clk = 0, reset_n = 0;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, a3_E, a3_M, a3_W, rt_M;
    logic [2:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic       md_use_D, md_start_E, md_div_E;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
    logic       stall, pc_en, fd_en, de_clr, md_busy;
    logic [3:0] stall_cnt;

    typedef struct {
        logic [1:0] d_rs, d_rt, e_rs, e_rt, m_rt;
        logic       stall, busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, m_left = 0, m_scnt = 0, nstall = 0;

    hazard_md_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_use_D(md_use_D),
        .rs_E(rs_E), .rt_E(rt_E), .a3_E(a3_E), .a3_M(a3_M), .a3_W(a3_W),
        .tnew_E(tnew_E), .tnew_M(tnew_M), .md_start_E(md_start_E), .md_div_E(md_div_E),
        .rt_M(rt_M), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
        .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .stall(stall), .pc_en(pc_en),
        .fd_en(fd_en), .de_clr(de_clr), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // stages scanned nearest first starting at lvl (0=E,1=M,2=W)
    function automatic logic [1:0] ref_fwd(input logic [4:0] s, input int lvl);
        logic [4:0] a[3];
        int tn[3];
        a = '{a3_E, a3_M, a3_W};
        tn = '{int'(tnew_E), int'(tnew_M), 0};
        for (int i = lvl; i < 3; i++)
            if (a[i] != 0 && a[i] == s) return (tn[i] == 0) ? 2'(i + 1) : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic ref_dstall(input logic [4:0] s, input logic [2:0] tu);
        logic r;
        r = 0;
        if (a3_E != 0 && a3_E == s && tnew_E > tu) r = 1;
        if (a3_M != 0 && a3_M == s && tnew_M > tu) r = 1;
        return r;
    endfunction

    task automatic cyc();
        exp_t e;
        int   left_now;
        left_now = md_start_E ? (md_div_E ? 10 : 5) : m_left;
        e.d_rs  = ref_fwd(rs_D, 0);
        e.d_rt  = ref_fwd(rt_D, 0);
        e.e_rs  = ref_fwd(rs_E, 1);
        e.e_rt  = ref_fwd(rt_E, 1);
        e.m_rt  = ref_fwd(rt_M, 2);
        e.busy  = left_now > 0;
        e.stall = ref_dstall(rs_D, tuse_rs_D) | ref_dstall(rt_D, tuse_rt_D) | (md_use_D & e.busy);
        e.cnt   = 4'(m_scnt);
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("fwd_d_rs", int'(fwd_d_rs), int'(e.d_rs));
        chk("fwd_d_rt", int'(fwd_d_rt), int'(e.d_rt));
        chk("fwd_e_rs", int'(fwd_e_rs), int'(e.e_rs));
        chk("fwd_e_rt", int'(fwd_e_rt), int'(e.e_rt));
        chk("fwd_m_rt", int'(fwd_m_rt), int'(e.m_rt));
        chk("stall", int'(stall), int'(e.stall));
        chk("pc_en", int'(pc_en), int'(!e.stall));
        chk("fd_en", int'(fd_en), int'(!e.stall));
        chk("de_clr", int'(de_clr), int'(e.stall));
        chk("md_busy", int'(md_busy), int'(e.busy));
        chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
        if (stall) nstall++;
        @(posedge clk);
        m_left = left_now > 0 ? left_now - 1 : 0;
        if (e.stall && m_scnt < 15) m_scnt++;
        #1;
    endtask

    task automatic clr_in();
        {rs_D, rt_D, rs_E, rt_E, a3_E, a3_M, a3_W, rt_M} = '0;
        {tuse_rs_D, tuse_rt_D, tnew_E, tnew_M} = '0;
        {md_use_D, md_start_E, md_div_E} = '0;
    endtask

    initial begin
        clr_in();
        md_start_E = 1;
        #3;
        chk("rst_cnt", int'(stall_cnt), 0);
        chk("rst_busy_start", int'(md_busy), 1);
        md_start_E = 0;
        #1;
        chk("rst_busy", int'(md_busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;

        a3_E = 8; tnew_E = 0; a3_M = 8; rs_D = 8; tuse_rs_D = 1;
        cyc();
        chk("prio_e", int'(fwd_d_rs), 1);
        tnew_E = 1;
        cyc();
        chk("prio_nofall", int'(fwd_d_rs), 0);
        chk("prio_nostall", int'(stall), 0);

        clr_in();
        a3_E = 3; tnew_E = 2; rt_D = 3; tuse_rt_D = 1;
        cyc();
        cyc();
        chk("lu_cnt", int'(stall_cnt), 2);
        a3_E = 0; tnew_E = 0; a3_M = 3; tnew_M = 1;
        cyc();
        chk("lu_clear", int'(stall), 0);

        clr_in();
        tnew_E = 2;
        cyc();
        chk("zero_stall", int'(stall), 0);

        clr_in();
        a3_M = 6; a3_W = 6; rs_E = 6; rt_E = 6; tnew_M = 0; rt_M = 6; rs_D = 6;
        cyc();
        a3_M = 0;
        cyc();

        clr_in();
        md_use_D = 1; md_start_E = 1; md_div_E = 1; nstall = 0;
        cyc();
        md_start_E = 0; md_div_E = 0;
        repeat (12) cyc();
        chk("div_len", nstall, 10);
        md_start_E = 1; nstall = 0;
        cyc();
        md_start_E = 0;
        repeat (8) cyc();
        chk("mult_len", nstall, 5);

        md_start_E = 1; md_div_E = 1;
        cyc();
        md_start_E = 0; md_div_E = 0;
        repeat (3) cyc();
        chk("pre_rst_busy", int'(md_busy), 1);
        #2 reset_n = 0;
        #1;
        chk("arst_busy", int'(md_busy), 0);
        chk("arst_cnt", int'(stall_cnt), 0);
        m_left = 0; m_scnt = 0;
        @(posedge clk); #1;
        reset_n = 1;
        cyc();
        chk("post_rst_busy", int'(md_busy), 0);

        clr_in();
        a3_E = 3; tnew_E = 2; rt_D = 3; tuse_rt_D = 1;
        repeat (20) cyc();
        chk("sat15", int'(stall_cnt), 15);
        cyc();
        chk("sat_hold", int'(stall_cnt), 15);

        for (int i = 0; i < 300; i++) begin
            {rs_D, rt_D, rs_E, rt_E} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            {a3_E, a3_M, a3_W, rt_M} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            {tuse_rs_D, tuse_rt_D} = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 2))};
            {tnew_E, tnew_M} = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 2))};
            md_use_D   = 1'($urandom_range(0, 1));
            md_start_E = ($urandom_range(0, 9) == 0);
            md_div_E   = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
